latch_stage_skid: RTL

Parametrised pipeline-stage latch carrying a register-writeback payload (write enable, address, data) between two pipeline stages. It adds a valid/ready handshake, a one-entry skid buffer and a synchronous flush, so upstream and downstream stages can stall independently without dropping or duplicating a transaction. It is the drop-in successor for every inter-stage latch in the CPU pipeline, instanced per stage boundary.

---
 rtl/cpu_latch_pkg.sv | 28 ++
 rtl/latch_stat_counter.sv | 33 +++
 rtl/latch_stage_skid.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cpu_latch_pkg.sv
// Shared constants for the inter-stage pipeline latches:
// state encoding, default payload widths and small helpers.
package cpu_latch_pkg;

   // Occupancy states of a skid-buffered stage latch
   localparam logic [1:0] STAGE_EMPTY = 2'd0;
   localparam logic [1:0] STAGE_FULL  = 2'd1;
   localparam logic [1:0] STAGE_SKID  = 2'd2;

   // Default register-writeback payload widths
   localparam int REG_ADDR_WIDTH = 5;
   localparam int REG_DATA_WIDTH = 32;

   // Main register holds a payload in FULL and SKID
   function automatic logic stage_main_valid(
      input logic [1:0] st
   );
      return (st == STAGE_FULL) || (st == STAGE_SKID);
   endfunction

   // Skid register holds a payload only in SKID
   function automatic logic stage_skid_valid(
      input logic [1:0] st
   );
      return st == STAGE_SKID;
   endfunction

endpackage

// File: rtl/latch_stat_counter.sv
// 32-bit saturating event counter with synchronous clear.
// Ports: clock, reset (sync, active-high), clear_i, inc_i, count_o.
module latch_stat_counter (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        inc_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/latch_stage_skid.sv
// Inter-stage writeback latch with valid/ready handshake,
// one-entry skid buffer and synchronous flush.
// Ports: clock, reset (sync, active-high), flush,
//   in_valid/in_ready + in_register_write_{enable,address,data},
//   out_valid/out_ready + out_register_write_{enable,address,data}.
// Optional macro LATCH_STAGE_STATS_EN adds saturating
//   stall_cycles / bubble_cycles counters (cleared by reset only).
module latch_stage_skid
   import cpu_latch_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_register_write_enable,
   input  logic [ADDR_WIDTH-1:0] in_register_write_address,
   input  logic [DATA_WIDTH-1:0] in_register_write_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_register_write_enable,
   output logic [ADDR_WIDTH-1:0] out_register_write_address,
   output logic [DATA_WIDTH-1:0] out_register_write_data
`ifdef LATCH_STAGE_STATS_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           bubble_cycles
`endif
);

   logic [1:0]            state_q, state_d;
   logic                  m_en_q, m_en_d;
   logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic                  s_en_q, s_en_d;
   logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
   logic [DATA_WIDTH-1:0] s_data_q, s_data_d;

   logic m_valid;
   logic s_valid;
   logic in_xfer;
   logic out_xfer;

   assign m_valid = stage_main_valid(state_q);
   assign s_valid = stage_skid_valid(state_q);

   // Ready depends on registered state only, never on out_ready
   assign in_ready = !s_valid && !reset;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = m_valid && out_ready;

   always_comb begin
      state_d  = state_q;
      m_en_d   = m_en_q;
      m_addr_d = m_addr_q;
      m_data_d = m_data_q;
      s_en_d   = s_en_q;
      s_addr_d = s_addr_q;
      s_data_d = s_data_q;

      unique case (state_q)
         STAGE_EMPTY: begin
            if (in_xfer) begin
               m_en_d   = in_register_write_enable;
               m_addr_d = in_register_write_address;
               m_data_d = in_register_write_data;
               state_d  = STAGE_FULL;
            end
         end
         STAGE_FULL: begin
            if (in_xfer && out_xfer) begin
               m_en_d   = in_register_write_enable;
               m_addr_d = in_register_write_address;
               m_data_d = in_register_write_data;
            end else if (in_xfer) begin
               // Downstream stalled: park the new entry
               s_en_d   = in_register_write_enable;
               s_addr_d = in_register_write_address;
               s_data_d = in_register_write_data;
               state_d  = STAGE_SKID;
            end else if (out_xfer) begin
               state_d = STAGE_EMPTY;
            end
         end
         STAGE_SKID: begin
            if (out_xfer) begin
               m_en_d   = s_en_q;
               m_addr_d = s_addr_q;
               m_data_d = s_data_q;
               state_d  = STAGE_FULL;
            end
         end
         default: begin
            state_d = STAGE_EMPTY;
         end
      endcase

      // Flush wins over any transfer; payloads left as-is
      if (flush) begin
         state_d = STAGE_EMPTY;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= STAGE_EMPTY;
         m_en_q   <= 1'b0;
         m_addr_q <= '0;
         m_data_q <= '0;
         s_en_q   <= 1'b0;
         s_addr_q <= '0;
         s_data_q <= '0;
      end else begin
         state_q  <= state_d;
         m_en_q   <= m_en_d;
         m_addr_q <= m_addr_d;
         m_data_q <= m_data_d;
         s_en_q   <= s_en_d;
         s_addr_q <= s_addr_d;
         s_data_q <= s_data_d;
      end
   end

   // Gate with reset so outputs read zero while reset is high,
   // even before the first clock edge clears the state
   assign out_valid = m_valid && !reset;

   assign out_register_write_enable =
      m_en_q && out_valid;
   assign out_register_write_address =
      out_valid ? m_addr_q : '0;
   assign out_register_write_data =
      out_valid ? m_data_q : '0;

`ifdef LATCH_STAGE_STATS_EN
   logic stall_inc;
   logic bubble_inc;

   assign stall_inc  = out_valid && !out_ready;
   assign bubble_inc = !out_valid && out_ready;

   latch_stat_counter u_stall_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear_i (1'b0),
      .inc_i   (stall_inc),
      .count_o (stall_cycles)
   );

   latch_stat_counter u_bubble_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear_i (1'b0),
      .inc_i   (bubble_inc),
      .count_o (bubble_cycles)
   );
`endif

endmodule
